// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared state encoding and constants for the instruction memory loader
package instr_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD    = 4;

endpackage

// File: rtl/instr_mem_loader_byte_word_assembler.sv
// rtl/instr_mem_loader_byte_word_assembler.sv - packs received bytes MSB-first into a memory word
module byte_word_assembler
    import instr_mem_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            rx_byte,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_ready
);

    logic [1:0] byte_idx;

    // High on the strobe that supplies the last byte of a word.
    assign word_ready = shift_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            word     <= {word[WORD_WIDTH-9:0], rx_byte};
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a UART byte stream into instruction memory as big-endian words
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int                        ADDR_WIDTH = 12,
    parameter int                        DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH*4-1:0]   HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_load_start,
    input  logic                      i_rx_valid,
    input  logic [7:0]                i_rx_byte,
    input  logic [ADDR_WIDTH-1:0]     i_cpu_addr,
    output logic                      o_mem_we,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH*4-1:0]   o_mem_data,
    output logic                      o_loading,
    output logic                      o_load_done,
    output logic                      o_full,
    output logic [ADDR_WIDTH-2:0]     o_word_count
);

    localparam int                    WORD_WIDTH = DATA_WIDTH * BYTES_PER_WORD;
    localparam logic [ADDR_WIDTH-1:0] LAST_SLOT  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [WORD_WIDTH-1:0]   word;
    logic                    word_ready;
    logic                    shift_en;
    logic                    start_taken;
    logic                    load_ends;

    // A byte arriving in the write cycle belongs to the next word unless the load is ending.
    assign load_ends   = (word == HALT_WORD) || (wr_ptr == LAST_SLOT);
    assign shift_en    = i_rx_valid &&
                         ((state == ST_RECV) || ((state == ST_WRITE) && !load_ends));
    assign start_taken = i_load_start && ((state == ST_IDLE) || (state == ST_DONE));

    assign o_mem_addr = o_loading ? wr_ptr : i_cpu_addr;
    assign o_mem_data = word;

    byte_word_assembler #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_assembler (
        .clk        (i_clk),
        .reset      (i_reset),
        .clear      (start_taken),
        .shift_en   (shift_en),
        .rx_byte    (i_rx_byte),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            o_word_count <= '0;
            o_full       <= 1'b0;
            o_load_done  <= 1'b0;
            o_mem_we     <= 1'b0;
            o_loading    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_load_start) begin
                        state        <= ST_RECV;
                        wr_ptr       <= '0;
                        o_word_count <= '0;
                        o_full       <= 1'b0;
                        o_load_done  <= 1'b0;
                        o_loading    <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (word_ready) begin
                        state    <= ST_WRITE;
                        o_mem_we <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    o_mem_we     <= 1'b0;
                    o_word_count <= o_word_count + (ADDR_WIDTH-1)'(1);
                    if (load_ends) begin
                        // Pointer is parked on the last slot so it can never wrap.
                        state       <= ST_DONE;
                        o_loading   <= 1'b0;
                        o_load_done <= 1'b1;
                        o_full      <= (word != HALT_WORD);
                    end else begin
                        state  <= ST_RECV;
                        wr_ptr <= wr_ptr + ADDR_WIDTH'(BYTES_PER_WORD);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader at two memory sizes
module tb_instr_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load_start, rx_valid;
    logic [7:0]  rx_byte;
    logic [11:0] cpu_addr;

    logic        we_a, loading_a, done_a, full_a;
    logic [11:0] addr_a;
    logic [31:0] data_a;
    logic [10:0] cnt_a;

    logic        we_b, loading_b, done_b, full_b;
    logic [3:0]  addr_b;
    logic [31:0] data_b;
    logic [2:0]  cnt_b;

    instr_mem_loader #(.ADDR_WIDTH(12)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_load_start(load_start),
        .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .i_cpu_addr(cpu_addr),
        .o_mem_we(we_a), .o_mem_addr(addr_a), .o_mem_data(data_a),
        .o_loading(loading_a), .o_load_done(done_a), .o_full(full_a),
        .o_word_count(cnt_a)
    );

    instr_mem_loader #(.ADDR_WIDTH(4)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_load_start(load_start),
        .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .i_cpu_addr(cpu_addr[3:0]),
        .o_mem_we(we_b), .o_mem_addr(addr_b), .o_mem_data(data_b),
        .o_loading(loading_b), .o_load_done(done_b), .o_full(full_b),
        .o_word_count(cnt_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_strobe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: index 0 is the 4 KiB memory, index 1 the 16-byte memory.
    int          nwords[2] = '{1024, 4};
    int          mask[2]   = '{32'hFFF, 32'hF};
    bit          model_valid = 1'b0;
    bit          m_load[2], m_done[2], m_full[2], m_wp[2];
    int          m_ptr[2], m_cnt[2], m_n[2];
    logic [7:0]  m_b[2][4];
    logic [31:0] m_word[2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                model_valid = 1'b1;
                m_load[k] = 0; m_done[k] = 0; m_full[k] = 0; m_wp[k] = 0;
                m_ptr[k] = 0; m_cnt[k] = 0; m_n[k] = 0;
            end else if (m_wp[k]) begin
                m_wp[k] = 0;
                m_cnt[k]++;
                m_ptr[k]++;
                if (m_word[k] == 32'hFFFF_FFFF || m_ptr[k] == nwords[k]) begin
                    m_load[k] = 0;
                    m_done[k] = 1;
                    m_full[k] = (m_word[k] != 32'hFFFF_FFFF);
                end else if (rx_valid) begin
                    m_b[k][0] = rx_byte;
                    m_n[k] = 1;
                end
            end else if (m_load[k]) begin
                if (rx_valid) begin
                    m_b[k][m_n[k]] = rx_byte;
                    m_n[k]++;
                    if (m_n[k] == 4) begin
                        m_word[k] = {m_b[k][0], m_b[k][1], m_b[k][2], m_b[k][3]};
                        m_wp[k] = 1;
                        m_n[k] = 0;
                    end
                end
            end else if (load_start) begin
                m_load[k] = 1; m_done[k] = 0; m_full[k] = 0;
                m_ptr[k] = 0; m_cnt[k] = 0; m_n[k] = 0;
            end
        end
    end

    task automatic compare(input int k, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic ld, input logic dn,
                           input logic fl, input logic [31:0] cnt);
        logic [31:0] exp_addr;
        exp_addr = m_load[k] ? 32'(m_ptr[k] * 4) : (32'(cpu_addr) & mask[k]);
        chk($sformatf("d%0d_we", k), 32'(we), 32'(m_wp[k]));
        chk($sformatf("d%0d_addr", k), addr, exp_addr);
        chk($sformatf("d%0d_loading", k), 32'(ld), 32'(m_load[k]));
        chk($sformatf("d%0d_done", k), 32'(dn), 32'(m_done[k]));
        chk($sformatf("d%0d_full", k), 32'(fl), 32'(m_full[k]));
        chk($sformatf("d%0d_count", k), cnt, 32'(m_cnt[k]));
        if (m_wp[k]) chk($sformatf("d%0d_data", k), data, m_word[k]);
    endtask

    logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
    int          wa_cyc[$];

    always @(negedge clk) begin
        if (model_valid) begin
            compare(0, we_a, 32'(addr_a), data_a, loading_a, done_a, full_a, 32'(cnt_a));
            compare(1, we_b, 32'(addr_b), data_b, loading_b, done_b, full_b, 32'(cnt_b));
            if (we_a === 1'b1) begin
                wa_addr.push_back(32'(addr_a)); wa_data.push_back(data_a); wa_cyc.push_back(cyc);
            end
            if (we_b === 1'b1) begin
                wb_addr.push_back(32'(addr_b)); wb_data.push_back(data_b);
            end
        end
    end

    task automatic apply(input logic st, input logic v, input logic [7:0] b);
        load_start = st; rx_valid = v; rx_byte = b;
        if (v) last_strobe = cyc;
        @(posedge clk); #1;
        load_start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, w[31-8*i -: 8]);
        if (gap) apply(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_logs();
        wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
        wb_addr.delete(); wb_data.delete();
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; cpu_addr = 12'h010;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        apply(1'b0, 1'b0, 8'h00);

        // Reset then idle: fetch address passes through.
        chk("idle_addr", 32'(addr_a), 32'h010);
        chk("idle_we", 32'(we_a), 0);
        chk("idle_loading", 32'(loading_a), 0);
        chk("idle_done", 32'(done_a), 0);
        chk("idle_data", data_a, 0);

        // Single word, written the cycle after the 4th strobe.
        clear_logs();
        apply(1'b1, 1'b0, 8'h00);
        send_word(32'h2001_0005, 1'b1);
        apply(1'b0, 1'b0, 8'h00);
        chk("single_nwrites", wa_addr.size(), 1);
        chk("single_addr", wa_addr[0], 32'h0);
        chk("single_data", wa_data[0], 32'h2001_0005);
        chk("single_latency", wa_cyc[0], last_strobe + 1);
        chk("single_count", 32'(cnt_a), 1);
        send_word(32'hFFFF_FFFF, 1'b1);

        // Halt termination after three words.
        clear_logs();
        apply(1'b1, 1'b0, 8'h00);
        send_word(32'h1111_1111, 1'b1);
        send_word(32'h2222_2222, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b1);
        apply(1'b0, 1'b0, 8'h00);
        chk("halt_nwrites", wa_addr.size(), 3);
        chk("halt_addr1", wa_addr[1], 32'h4);
        chk("halt_addr2", wa_addr[2], 32'h8);
        chk("halt_data0", wa_data[0], 32'h1111_1111);
        chk("halt_data2", wa_data[2], 32'hFFFF_FFFF);
        chk("halt_done", 32'(done_a), 1);
        chk("halt_full", 32'(full_a), 0);
        chk("halt_count", 32'(cnt_a), 3);
        cpu_addr = 12'h3A4;
        apply(1'b0, 1'b0, 8'h00);
        chk("halt_passthru", 32'(addr_a), 32'h3A4);

        // Start with a simultaneous byte, then a byte in the write cycle.
        clear_logs();
        apply(1'b1, 1'b1, 8'h99);
        send_word(32'hA1B2_C3D4, 1'b0);
        send_word(32'h5566_7788, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b1);
        chk("b2b_nwrites", wa_addr.size(), 3);
        chk("b2b_data0", wa_data[0], 32'hA1B2_C3D4);
        chk("b2b_addr1", wa_addr[1], 32'h4);
        chk("b2b_data1", wa_data[1], 32'h5566_7788);

        // Small memory fills; the byte in its last write cycle is dropped.
        clear_logs();
        apply(1'b1, 1'b0, 8'h00);
        send_word(32'h0102_0304, 1'b1);
        send_word(32'h0506_0708, 1'b1);
        send_word(32'h090A_0B0C, 1'b1);
        send_word(32'h0D0E_0F10, 1'b0);
        apply(1'b0, 1'b1, 8'hEE);
        send_word(32'h1122_3344, 1'b1);
        chk("full_nwrites", wb_addr.size(), 4);
        chk("full_addr3", wb_addr[3], 32'hC);
        chk("full_data3", wb_data[3], 32'h0D0E_0F10);
        chk("full_flag", 32'(full_b), 1);
        chk("full_done", 32'(done_b), 1);
        chk("full_count", 32'(cnt_b), 4);
        chk("big_addr4", wa_addr[4], 32'h10);
        chk("big_data4", wa_data[4], 32'hEE11_2233);

        // Reset mid-load discards the partial word.
        clear_logs();
        apply(1'b1, 1'b0, 8'h00);
        apply(1'b0, 1'b1, 8'hAB);
        apply(1'b0, 1'b1, 8'hCD);
        reset = 1'b1;
        apply(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        apply(1'b0, 1'b0, 8'h00);
        chk("rst_nwrites_a", wa_addr.size(), 0);
        chk("rst_nwrites_b", wb_addr.size(), 0);
        chk("rst_loading", 32'(loading_a), 0);
        apply(1'b1, 1'b0, 8'h00);
        send_word(32'hCAFE_BABE, 1'b1);
        chk("rst_restart_addr", wa_addr[0], 32'h0);
        chk("rst_restart_data", wa_data[0], 32'hCAFE_BABE);
        chk("rst_restart_b", wb_data[0], 32'hCAFE_BABE);

        apply(1'b0, 1'b0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Sequencer for the byte-addressed instruction memory (4 bytes per word, MSB at lowest address, combinational read, write on clock edge).
- Receives the program as a UART byte stream, assembles 32-bit big-endian words and writes them at consecutive word addresses.
- Owns the memory address/write port during a load; passes the CPU fetch address through otherwise.
- Sits between the UART receiver, the processor PC and the instruction memory.

Parameters:
- ADDR_WIDTH, 12: memory byte-address width (2**ADDR_WIDTH bytes).
- DATA_WIDTH, 8: memory cell width; the word is DATA_WIDTH*4 bits.
- HALT_WORD, 32'hFFFFFFFF: end-of-program word. It is written to memory, then the load terminates.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_load_start, input, 1: one-cycle pulse that starts a load.
- i_rx_valid, input, 1: one-cycle strobe; i_rx_byte is valid.
- i_rx_byte, input, 8: received byte.
- i_cpu_addr, input, ADDR_WIDTH: CPU fetch address (PC).
- o_mem_we, output, 1: memory write enable.
- o_mem_addr, output, ADDR_WIDTH: memory byte address.
- o_mem_data, output, DATA_WIDTH*4: memory write word.
- o_loading, output, 1: high in RECV and WRITE; CPU must stall.
- o_load_done, output, 1: level, high in DONE.
- o_full, output, 1: load ended because the memory filled without HALT_WORD.
- o_word_count, output, ADDR_WIDTH-1: words written in the current or last load.

Behaviour:
- Reset (i_reset high at a clock edge):
  - State goes to IDLE.
  - wr_ptr, byte_idx, shift register, o_word_count, o_full and o_load_done all clear to 0.
  - o_mem_we=0 and o_mem_data=0.
  - Reset mid-load discards the partial word and issues no write.
- o_mem_addr:
  - In IDLE and DONE: i_cpu_addr, combinationally.
  - In RECV and WRITE: wr_ptr.
- o_mem_we is high only in WRITE.
- IDLE:
  - i_load_start moves to RECV, with wr_ptr=0, byte_idx=0, o_word_count=0, o_full=0.
  - i_rx_valid is ignored.
- RECV:
  - Each i_rx_valid does shift <= {shift[23:0], i_rx_byte} and byte_idx += 1. The first byte received ends up as the MSB.
  - The strobe that completes the 4th byte moves to WRITE on the next edge. byte_idx wraps to 0.
  - i_load_start is ignored.
- WRITE (exactly one cycle):
  - o_mem_we=1, o_mem_addr=wr_ptr, o_mem_data=shift.
  - At the edge: wr_ptr += 4 and o_word_count += 1.
  - If shift == HALT_WORD, go to DONE.
  - Else if wr_ptr == 2**ADDR_WIDTH-4 (last slot just written), go to DONE and set o_full=1.
  - Otherwise return to RECV.
  - An i_rx_valid in WRITE is captured as byte 0 of the next word (byte_idx=1); no byte is lost.
  - If the next state is DONE, that byte is dropped.
- Write latency: the write occurs in the cycle after the 4th byte strobe.
- DONE:
  - o_load_done=1; the address passes through to the CPU.
  - i_rx_valid is ignored.
  - i_load_start restarts exactly as from IDLE and clears o_load_done and o_full on the same edge.
- i_load_start and i_rx_valid together in IDLE or DONE: the start is taken and the byte is ignored.
- wr_ptr is always word-aligned (bits [1:0] = 0). It never wraps, because DONE is forced at the last slot.
- o_word_count saturates naturally at 2**(ADDR_WIDTH-2).

Decomposition:
- Shared package: state encoding localparams (IDLE=0, RECV=1, WRITE=2, DONE=3), the HALT_WORD default, and BYTES_PER_WORD=4.
- One natural sub-module, byte_word_assembler: the 4-byte shift register, byte_idx counter and word-ready pulse.
- The FSM, pointer and address mux stay in the top module.

Test Plan:
- Reset then idle: drive i_cpu_addr=12'h010 -> o_mem_addr=12'h010, o_mem_we=0, o_loading=0, o_load_done=0.
- Single word: start, then bytes 8'h20,8'h01,8'h00,8'h05 -> exactly one o_mem_we pulse, the cycle after the 4th strobe, with addr=0 and data=32'h20010005; o_word_count=1.
- Halt termination: words 32'h11111111, 32'h22222222, then 32'hFFFFFFFF -> writes at addr 0, 4, 8; DONE; o_load_done=1; o_full=0; o_word_count=3; o_mem_addr then follows i_cpu_addr.
- Back-to-back bytes: a strobe in the WRITE cycle -> it becomes the MSB of word 2, which is written at addr 4 with correct data.
- Full memory (ADDR_WIDTH=4): 4 non-halt words -> writes at 0, 4, 8, 12; then DONE with o_full=1 and o_word_count=4; further bytes cause no writes.
- Reset mid-load: 2 bytes, then i_reset for one cycle -> no write, IDLE; a later restart writes the next word at addr 0.
